// File: rtl/display_mux_scheduler_if.sv
// Update channel for display_mux_scheduler: one hex nibble per digit,
// transferred with a valid/ready handshake.
interface display_mux_scheduler_if #(
    parameter int N_DIGITS = 2
);
    logic                  update_valid;
    logic                  update_ready;
    logic [4*N_DIGITS-1:0] update_data;

    modport master (
        output update_valid,
        output update_data,
        input  update_ready
    );

    modport slave (
        input  update_valid,
        input  update_data,
        output update_ready
    );
endinterface

// File: rtl/display_mux_scheduler.sv
// Multiplexes one active-low 7-segment bus across N_DIGITS common-anode digits,
// with blanking between digits and frame-aligned commit of new display values.
module display_mux_scheduler #(
    parameter int N_DIGITS     = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic                          clk,
    input  logic                          reset_n,
    display_mux_scheduler_if.slave        upd,
    input  logic [N_DIGITS-1:0]           digit_en,
    output logic [6:0]                    seg,
    output logic [N_DIGITS-1:0]           an,
    output logic                          frame_done
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [IW-1:0] LAST_IDX      = IW'(N_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_LAST    = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST    = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_PRELAST = CW'(DWELL_CYCLES - 2);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*N_DIGITS-1:0] shadow;
    logic [4*N_DIGITS-1:0] pending;
    logic                  pending_full;

    logic                  blank_last;
    logic                  drive_last;
    logic [IW-1:0]         idx_next;
    logic [3:0]            cur_nibble;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign blank_last = (state == BLANK) && (cnt == BLANK_LAST);
    assign drive_last = (state == DRIVE) && (cnt == DWELL_LAST);
    assign idx_next   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    assign cur_nibble = shadow[{idx, 2'b00} +: 4];

    // Ready is simply "pending slot empty", which is itself a register.
    assign upd.update_ready = ~pending_full;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= BLANK;
            cnt          <= '0;
            idx          <= '0;
            seg          <= 7'h7F;
            an           <= '1;
            frame_done   <= 1'b0;
            shadow       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            unique case (state)
                BLANK: begin
                    if (blank_last) begin
                        state <= DRIVE;
                        cnt   <= '0;
                        if (digit_en[idx]) begin
                            an  <= ~(N_DIGITS'(1) << idx);
                            seg <= decode(cur_nibble);
                        end else begin
                            an  <= '1;
                            seg <= 7'h7F;
                        end
                        frame_done <= (idx == LAST_IDX) && (DWELL_CYCLES == 1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRIVE: begin
                    if (drive_last) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= idx_next;
                        an    <= '1;
                        seg   <= 7'h7F;
                    end else begin
                        cnt <= cnt + CW'(1);
                        // Register the pulse so it lands on the slot's final cycle.
                        if ((DWELL_CYCLES >= 2) && (idx == LAST_IDX) && (cnt == DWELL_PRELAST)) begin
                            frame_done <= 1'b1;
                        end
                    end
                end
            endcase

            // Commit happens only at the frame boundary; a capture in that
            // same cycle is impossible because ready is low while pending is full.
            if (frame_done && pending_full) begin
                shadow       <= pending;
                pending_full <= 1'b0;
            end else if (upd.update_valid && !pending_full) begin
                pending      <= upd.update_data;
                pending_full <= 1'b1;
            end
        end
    end

endmodule
